cnn_layer_sequencer: RTL and testbench
======================================

Name: cnn_layer_sequencer

Overview:
Parametrised forward-pass sequencer for the CNN accelerator. It steps through NUM_CONV convolution layers, each with five stages: weight load, input load, systolic compute, result register and pooling. It then runs NUM_FC fully-connected layers. Each stage gets one shared one-hot load vector plus layer/FC index outputs, replacing per-layer strobe ports. Additions: per-layer pooling bypass, abort, busy flag and an optional stage watchdog.

Parameters:
NUM_CONV, 2, number of conv layers (1..8)
NUM_FC, 2, number of FC layers (0..8)
IDX_W, 3, width of layer_idx/fc_idx (must hold max(NUM_CONV,NUM_FC)-1)
TIMEOUT_CYCLES, 1024, watchdog limit per stage (used only with STAGE_TIMEOUT_EN)
TO_W, 16, watchdog counter width

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
start_bit  in  1  start forward pass; sampled only in IDLE
abort  in  1  cancel pass; highest priority
pool_bypass  in  NUM_CONV  bit k=1 skips POOL for conv layer k
done_w, done_i, done_s, done_r, done_p  in  1 each  stage-complete pulses from datapath
done_fc  in  1  FC layer complete
stage_load  out  5  one-hot {w,i,s,r,p} load for current conv stage
layer_idx  out  IDX_W  current conv layer
fc_load  out  1  FC layer active
fc_idx  out  IDX_W  current FC layer
busy  out  1  high in every state except IDLE
done_fwd  out  1  one-cycle pulse at end of pass
error  out  1  sticky watchdog flag (0 without STAGE_TIMEOUT_EN)

Behaviour:
- States: IDLE, WEIGHT, INPUT, SYS, REG, POOL, FC, DONE. Plus layer_idx and fc_idx counters.
- Moore outputs: decoded from registered state and counters only; no combinational input-to-output path.
- Reset (async, reset_n=0): state=IDLE, counters=0, all outputs 0, error=0.
- IDLE: start_bit=1 at edge -> WEIGHT, layer_idx=0, fc_idx=0, error cleared. stage_load=5'b10000 in the following cycle (1-cycle latency).
- Stage advance: the done pulse matching the current stage moves WEIGHT->INPUT->SYS->REG->POOL. Done inputs for any other stage are ignored.
- REG + done_r: if pool_bypass[layer_idx]=1, take the POOL-exit path directly; otherwise -> POOL.
- POOL exit (done_p): if layer_idx<NUM_CONV-1, then layer_idx+1 and -> WEIGHT. Else -> FC with fc_idx=0, or -> DONE if NUM_FC=0.
- FC + done_fc: if fc_idx<NUM_FC-1, then fc_idx+1 and stay in FC. fc_load drops for exactly one cycle between layers so the FC engine sees a fresh rising edge. Else -> DONE.
- DONE: done_fwd=1 for one cycle, then -> IDLE. start_bit high in that IDLE cycle begins a new pass.
- abort=1 in any non-IDLE state: -> IDLE next edge, counters zeroed, no done_fwd. abort beats a simultaneous done.
- start_bit outside IDLE is ignored.
- Output encoding: stage_load is one-hot in WEIGHT..POOL and 0 elsewhere. fc_load=1 only in FC (except the 1-cycle gap). layer_idx holds its last value during FC/DONE and resets to 0 in IDLE.
- Illegal state encoding -> IDLE.

Optional Feature:
STAGE_TIMEOUT_EN
- Defined: a TO_W-bit counter clears on every state change and increments each cycle spent in a stage. When it reaches TIMEOUT_CYCLES-1 without the matching done, the next edge sets error=1 and goes to IDLE. error stays high until reset or the next accepted start_bit. A done arriving on the terminal cycle wins over the timeout.
- Undefined: no counter logic, error tied to 0, stages wait indefinitely.

Test Plan:
- Full pass, NUM_CONV=2, NUM_FC=2, each done 3 cycles after stage entry -> stage_load sequence 10000,01000,00100,00010,00001 with layer_idx 0 then 1. Then fc_idx 0,1. done_fwd high exactly 1 cycle. Total 38 cycles from start to done_fwd.
- pool_bypass=2'b01 -> layer 0 goes REG->WEIGHT (layer_idx=1) with no 00001 phase; layer 1 pools normally.
- abort asserted in SYS of layer 1 together with done_s -> IDLE next cycle, all outputs 0, busy=0, no done_fwd.
- Spurious done_p/done_fc pulses during WEIGHT, and start_bit pulses during INPUT -> no state change.
- NUM_FC=0 -> POOL of last layer goes straight to DONE; fc_load never asserts.
- STAGE_TIMEOUT_EN, TIMEOUT_CYCLES=16, done_s withheld -> IDLE after 16 SYS cycles, error=1; the next start_bit clears error.

Source files
------------

// File: rtl/cnn_layer_sequencer.sv
// cnn_layer_sequencer: forward-pass sequencer stepping conv layers (W/I/S/R/P stages) then FC layers.
// Ports: clk, reset_n (async active-low); start_bit, abort, pool_bypass[NUM_CONV];
//   done_w/i/s/r/p, done_fc stage-complete pulses; stage_load one-hot {w,i,s,r,p};
//   layer_idx, fc_load, fc_idx, busy, done_fwd (1-cycle), error (sticky watchdog flag).
// Optional: define STAGE_TIMEOUT_EN to enable the per-stage watchdog; otherwise error is tied low.
module cnn_layer_sequencer #(
  parameter int NUM_CONV       = 2,
  parameter int NUM_FC         = 2,
  parameter int IDX_W          = 3,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TO_W           = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start_bit,
  input  logic                abort,
  input  logic [NUM_CONV-1:0] pool_bypass,
  input  logic                done_w,
  input  logic                done_i,
  input  logic                done_s,
  input  logic                done_r,
  input  logic                done_p,
  input  logic                done_fc,
  output logic [4:0]          stage_load,
  output logic [IDX_W-1:0]    layer_idx,
  output logic                fc_load,
  output logic [IDX_W-1:0]    fc_idx,
  output logic                busy,
  output logic                done_fwd,
  output logic                error
);
  typedef enum logic [2:0] {IDLE, WEIGHT, INPUT, SYS, REG, POOL, FC, DONE} state_t;
  localparam int BW = 1 << IDX_W;
  state_t state, state_n, exit_s;
  logic [IDX_W-1:0] layer_n, fc_n, exit_l;
  logic [BW-1:0] byp;
  logic gap, gap_n, last_conv;
  // widen so the bypass bit can be indexed directly by layer_idx
  assign byp = BW'(pool_bypass);
  assign last_conv = layer_idx == IDX_W'(NUM_CONV - 1);
  // where a conv layer goes once its pooling (or bypassed pooling) completes
  assign exit_s = !last_conv ? WEIGHT : (NUM_FC == 0 ? DONE : FC);
  assign exit_l = last_conv ? layer_idx : layer_idx + IDX_W'(1);
`ifdef STAGE_TIMEOUT_EN
  logic [TO_W-1:0] to_cnt;
  logic hit, err_n;
  // matching done for the current stage; a done on the terminal cycle beats the timeout
  assign hit = state == WEIGHT ? done_w :
               state == INPUT  ? done_i :
               state == SYS    ? done_s :
               state == REG    ? done_r :
               state == POOL   ? done_p :
               state == FC     ? done_fc && !gap : 1'b0;
`endif
  always_comb begin
    state_n = state;
    layer_n = layer_idx;
    fc_n    = fc_idx;
    gap_n   = 1'b0;
`ifdef STAGE_TIMEOUT_EN
    err_n   = (state == IDLE && start_bit) ? 1'b0 : error;
`endif
    case (state)
      IDLE:   state_n = start_bit ? WEIGHT : IDLE;
      WEIGHT: state_n = done_w ? INPUT : WEIGHT;
      INPUT:  state_n = done_i ? SYS : INPUT;
      SYS:    state_n = done_s ? REG : SYS;
      REG: if (done_r) begin
        state_n = byp[layer_idx] ? exit_s : POOL;
        layer_n = byp[layer_idx] ? exit_l : layer_idx;
      end
      POOL: if (done_p) begin
        state_n = exit_s;
        layer_n = exit_l;
      end
      // gap drops fc_load for one cycle so the FC engine sees a fresh rising edge
      FC: if (done_fc && !gap) begin
        if (fc_idx < IDX_W'(NUM_FC - 1)) begin
          fc_n  = fc_idx + IDX_W'(1);
          gap_n = 1'b1;
        end else state_n = DONE;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
`ifdef STAGE_TIMEOUT_EN
    if (state != IDLE && state != DONE && !hit && to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
      state_n = IDLE;
      err_n   = 1'b1;
    end
`endif
    if (abort && state != IDLE) state_n = IDLE;
    if (state_n == IDLE) begin
      layer_n = '0;
      fc_n    = '0;
      gap_n   = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      layer_idx <= '0;
      fc_idx    <= '0;
      gap       <= 1'b0;
    end else begin
      state     <= state_n;
      layer_idx <= layer_n;
      fc_idx    <= fc_n;
      gap       <= gap_n;
    end
  end
`ifdef STAGE_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      to_cnt <= '0;
      error  <= 1'b0;
    end else begin
      to_cnt <= (state_n != state || hit || gap || state == IDLE) ? '0 : to_cnt + TO_W'(1);
      error  <= err_n;
    end
  end
`else
  assign error = 1'b0;
`endif
  assign stage_load = state == WEIGHT ? 5'b10000 :
                      state == INPUT  ? 5'b01000 :
                      state == SYS    ? 5'b00100 :
                      state == REG    ? 5'b00010 :
                      state == POOL   ? 5'b00001 : 5'b00000;
  assign fc_load  = state == FC && !gap;
  assign busy     = state != IDLE;
  assign done_fwd = state == DONE;
endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// tb_cnn_layer_sequencer: scoreboard bench for cnn_layer_sequencer (u0: 2 conv/2 FC, u1: 2 conv/no FC).
module tb_cnn_layer_sequencer;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n, ab, sp_p, sp_fc;
  logic st[2], hold[2];
  logic [1:0] pb[2];
  logic [5:0] dn[2];
  logic [4:0] sl[2];
  logic [2:0] li[2], fi[2];
  logic fl[2], bz[2], dfw[2], er[2];
  int checks = 0, errors = 0;
  logic [14:0] q[$];
  bit fc_seen = 0;
  int rcnt[2];
  logic [11:0] rprv[2];

  cnn_layer_sequencer #(.NUM_CONV(2), .NUM_FC(2), .IDX_W(3), .TIMEOUT_CYCLES(16), .TO_W(16)) u0 (
    .clk(clk), .reset_n(reset_n), .start_bit(st[0]), .abort(ab), .pool_bypass(pb[0]),
    .done_w(dn[0][5]), .done_i(dn[0][4]), .done_s(dn[0][3]), .done_r(dn[0][2]),
    .done_p(dn[0][1] | sp_p), .done_fc(dn[0][0] | sp_fc),
    .stage_load(sl[0]), .layer_idx(li[0]), .fc_load(fl[0]), .fc_idx(fi[0]),
    .busy(bz[0]), .done_fwd(dfw[0]), .error(er[0]));

  cnn_layer_sequencer #(.NUM_CONV(2), .NUM_FC(0), .IDX_W(3), .TIMEOUT_CYCLES(16), .TO_W(16)) u1 (
    .clk(clk), .reset_n(reset_n), .start_bit(st[1]), .abort(ab), .pool_bypass(pb[1]),
    .done_w(dn[1][5]), .done_i(dn[1][4]), .done_s(dn[1][3]), .done_r(dn[1][2]),
    .done_p(dn[1][1]), .done_fc(dn[1][0]),
    .stage_load(sl[1]), .layer_idx(li[1]), .fc_load(fl[1]), .fc_idx(fi[1]),
    .busy(bz[1]), .done_fwd(dfw[1]), .error(er[1]));

  function automatic logic [14:0] v(input logic b, input logic [4:0] s, input logic [2:0] l,
                                    input logic f, input logic [2:0] x, input logic d, input logic e);
    return {b, s, l, f, x, d, e};
  endfunction

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", n, got, exp);
    end
  endtask

  // datapath model: each stage completes on its 3rd cycle
  initial begin
    dn[0] = '0; dn[1] = '0; rcnt[0] = 0; rcnt[1] = 0; rprv[0] = '0; rprv[1] = '0;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (sl[k] == 5'b0 && !fl[k]) rcnt[k] = 0;
        else if ({sl[k], fl[k], li[k], fi[k]} == rprv[k]) rcnt[k]++;
        else rcnt[k] = 1;
        rprv[k] = {sl[k], fl[k], li[k], fi[k]};
        if (k == 1 && fl[k]) fc_seen = 1;
        dn[k] = (rcnt[k] == 3) ? {sl[k][4], sl[k][3], sl[k][2] & !hold[k], sl[k][1], sl[k][0], fl[k]} : 6'b0;
      end
    end
  end

  // monitor: every change of u0's outputs is checked against the next expected vector
  initial begin
    logic [14:0] prev, cur;
    prev = '0;
    forever begin
      @(negedge clk);
      #1;
      cur = {bz[0], sl[0], li[0], fl[0], fi[0], dfw[0], er[0]};
      if (cur !== prev) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output got %h expected none", cur);
        end else chk("sb_output", {17'b0, cur}, {17'b0, q.pop_front()});
        prev = cur;
      end
    end
  end

  task automatic push_conv(input logic [2:0] l, input bit byp);
    q.push_back(v(1, 5'b10000, l, 0, 0, 0, 0));
    q.push_back(v(1, 5'b01000, l, 0, 0, 0, 0));
    q.push_back(v(1, 5'b00100, l, 0, 0, 0, 0));
    q.push_back(v(1, 5'b00010, l, 0, 0, 0, 0));
    if (!byp) q.push_back(v(1, 5'b00001, l, 0, 0, 0, 0));
  endtask

  task automatic push_tail();
    q.push_back(v(1, 5'b0, 1, 1, 0, 0, 0));
    q.push_back(v(1, 5'b0, 1, 0, 1, 0, 0));
    q.push_back(v(1, 5'b0, 1, 1, 1, 0, 0));
    q.push_back(v(1, 5'b0, 1, 0, 1, 1, 0));
    q.push_back(v(0, 5'b0, 0, 0, 0, 0, 0));
  endtask

  task automatic pulse_start(input int k);
    @(negedge clk);
    st[k] = 1;
    @(negedge clk);
    #2;
    st[k] = 0;
  endtask

  task automatic run_pass(input int k, input int exp, input string name);
    int n;
    pulse_start(k);
    n = 1;
    while (!dfw[k] && n < 300) begin
      @(negedge clk);
      #2;
      n++;
    end
    chk(name, n, exp);
  endtask

  task automatic wait_sys(input string name);
    int n;
    n = 0;
    while (sl[0] != 5'b00100 && n < 100) begin
      @(negedge clk);
      #2;
      n++;
    end
    chk(name, n < 100, 1);
  endtask

  task automatic spurious();
    int n;
    n = 0;
    while (sl[0] != 5'b10000 && n < 100) begin
      @(negedge clk);
      #3;
      n++;
    end
    chk("spur_weight_reached", n < 100, 1);
    sp_p = 1; sp_fc = 1;
    @(negedge clk);
    #3;
    sp_p = 0; sp_fc = 0;
    n = 0;
    while (sl[0] != 5'b01000 && n < 100) begin
      @(negedge clk);
      #3;
      n++;
    end
    chk("spur_input_reached", n < 100, 1);
    st[0] = 1;
    @(negedge clk);
    #3;
    st[0] = 0;
  endtask

  initial begin
    int n, m;
    reset_n = 0; ab = 0; sp_p = 0; sp_fc = 0;
    for (int k = 0; k < 2; k++) begin st[k] = 0; hold[k] = 0; pb[k] = '0; end
    repeat (3) @(negedge clk);
    reset_n = 1;
    @(negedge clk);
    #2;
    chk("reset_u0", {bz[0], sl[0], li[0], fl[0], fi[0], dfw[0], er[0]}, 0);
    chk("reset_u1", {bz[1], sl[1], li[1], fl[1], fi[1], dfw[1], er[1]}, 0);
    push_conv(0, 0); push_conv(1, 0); push_tail();
    fork
      run_pass(0, 38, "full_pass_cycles");
      spurious();
    join
    pb[0] = 2'b01;
    push_conv(0, 1); push_conv(1, 0); push_tail();
    run_pass(0, 35, "bypass_pass_cycles");
    pb[0] = 2'b00;
    push_conv(0, 0);
    q.push_back(v(1, 5'b10000, 1, 0, 0, 0, 0));
    q.push_back(v(1, 5'b01000, 1, 0, 0, 0, 0));
    q.push_back(v(1, 5'b00100, 1, 0, 0, 0, 0));
    q.push_back(v(0, 5'b0, 0, 0, 0, 0, 0));
    pulse_start(0);
    n = 0;
    while (!(sl[0] == 5'b00100 && li[0] == 3'd1 && dn[0][3]) && n < 300) begin
      @(negedge clk);
      #2;
      n++;
    end
    chk("abort_point_reached", n < 300, 1);
    ab = 1;
    @(negedge clk);
    #2;
    ab = 0;
    chk("abort_idle", {bz[0], sl[0], li[0], fl[0], dfw[0]}, 0);
    repeat (3) @(negedge clk);
    hold[0] = 1;
    q.push_back(v(1, 5'b10000, 0, 0, 0, 0, 0));
    q.push_back(v(1, 5'b01000, 0, 0, 0, 0, 0));
    q.push_back(v(1, 5'b00100, 0, 0, 0, 0, 0));
`ifdef STAGE_TIMEOUT_EN
    q.push_back(v(0, 5'b0, 0, 0, 0, 0, 1));
    q.push_back(v(1, 5'b10000, 0, 0, 0, 0, 0));
    q.push_back(v(0, 5'b0, 0, 0, 0, 0, 0));
    pulse_start(0);
    wait_sys("timeout_sys_reached");
    m = 0;
    while (sl[0] == 5'b00100 && m < 100) begin
      m++;
      @(negedge clk);
      #2;
    end
    chk("timeout_sys_cycles", m, 16);
    chk("timeout_error_set", er[0], 1);
    chk("timeout_idle", bz[0], 0);
    pulse_start(0);
    chk("error_cleared_by_start", er[0], 0);
`else
    q.push_back(v(0, 5'b0, 0, 0, 0, 0, 0));
    pulse_start(0);
    wait_sys("hold_sys_reached");
    repeat (40) @(negedge clk);
    #2;
    chk("hold_still_sys", sl[0], 5'b00100);
    chk("hold_no_error", er[0], 0);
`endif
    ab = 1;
    @(negedge clk);
    #2;
    ab = 0;
    hold[0] = 0;
    repeat (3) @(negedge clk);
    run_pass(1, 31, "nofc_pass_cycles");
    chk("nofc_done_layer", li[1], 1);
    chk("nofc_done_stage", sl[1], 0);
    chk("nofc_fc_load_never", fc_seen, 0);
    repeat (5) @(negedge clk);
    #2;
    chk("nofc_idle", bz[1], 0);
    chk("scoreboard_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
